// File: rtl/grf_wb_sink_if.sv
// rtl/grf_wb_sink_if.sv - GRF read/writeback/issue signal bundle
interface grf_wb_sink_if #(
  parameter int DATA_W = 32
) ();
  logic [4:0]        ra1;
  logic [4:0]        ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              we;
  logic [4:0]        wa;
  logic [DATA_W-1:0] wd;
  logic              iss_en;
  logic [4:0]        iss_addr;
  logic              iss_ready;
  logic              busy1;
  logic              busy2;
  logic              stall;
  logic              err;

  modport master (
    output ra1, ra2, we, wa, wd, iss_en, iss_addr,
    input  rd1, rd2, iss_ready, busy1, busy2, stall, err
  );

  modport slave (
    input  ra1, ra2, we, wa, wd, iss_en, iss_addr,
    output rd1, rd2, iss_ready, busy1, busy2, stall, err
  );
endinterface

// File: rtl/grf_wb_sink.sv
// rtl/grf_wb_sink.sv - 32x32 register file with bypass and pending-write scoreboard
module grf_wb_sink #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
) (
  input logic          clk,
  input logic          reset,
  grf_wb_sink_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // $0 has no storage; arrays start at index 1.
  logic [DATA_W-1:0] r_regs [1:31];
  logic [CNT_W-1:0]  r_cnt  [1:31];
  logic              r_err;

  logic [CNT_W-1:0]  w_cnt_ra1;
  logic [CNT_W-1:0]  w_cnt_ra2;
  logic [CNT_W-1:0]  w_cnt_iss;
  logic              w_hit1;
  logic              w_hit2;
  logic              w_iss_ready;
  logic              w_busy1;
  logic              w_busy2;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [31:1]       w_inc;
  logic [31:1]       w_dec;
  logic              w_underflow;

  // Counter lookups for the read and issue addresses; address 0 reads as idle.
  always_comb begin
    w_cnt_ra1 = '0;
    w_cnt_ra2 = '0;
    w_cnt_iss = '0;
    if (bus.ra1 != 5'd0)      w_cnt_ra1 = r_cnt[bus.ra1];
    if (bus.ra2 != 5'd0)      w_cnt_ra2 = r_cnt[bus.ra2];
    if (bus.iss_addr != 5'd0) w_cnt_iss = r_cnt[bus.iss_addr];
  end

  // Read ports with same-cycle writeback bypass; a retiring writer no longer counts as busy.
  always_comb begin
    w_hit1 = bus.we && (bus.wa == bus.ra1);
    w_hit2 = bus.we && (bus.wa == bus.ra2);
    w_rd1  = '0;
    w_rd2  = '0;
    if (bus.ra1 != 5'd0) w_rd1 = w_hit1 ? bus.wd : r_regs[bus.ra1];
    if (bus.ra2 != 5'd0) w_rd2 = w_hit2 ? bus.wd : r_regs[bus.ra2];
    w_busy1 = (bus.ra1 != 5'd0) && (w_cnt_ra1 > CNT_W'(w_hit1));
    w_busy2 = (bus.ra2 != 5'd0) && (w_cnt_ra2 > CNT_W'(w_hit2));
    // A saturated counter can still take an issue when the same register retires now.
    w_iss_ready = (bus.iss_addr == 5'd0) || (w_cnt_iss != CNT_MAX) ||
                  (bus.we && (bus.wa == bus.iss_addr));
  end

  // Per-register issue/retire strobes and underflow detection.
  always_comb begin
    w_inc       = '0;
    w_dec       = '0;
    w_underflow = 1'b0;
    for (int r = 1; r < 32; r++) begin
      w_inc[r] = bus.iss_en && w_iss_ready && (bus.iss_addr == 5'(r));
      w_dec[r] = bus.we && (bus.wa == 5'(r));
      if (w_dec[r] && !w_inc[r] && (r_cnt[r] == '0)) w_underflow = 1'b1;
    end
  end

  // Register storage; writes to $0 are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 1; r < 32; r++) r_regs[r] <= '0;
    end else if (bus.we && (bus.wa != 5'd0)) begin
      r_regs[bus.wa] <= bus.wd;
    end
  end

  // In-flight counters: saturate-free by iss_ready, clamp at zero and flag underflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 1; r < 32; r++) r_cnt[r] <= '0;
      r_err <= 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (w_inc[r] && !w_dec[r]) begin
          r_cnt[r] <= r_cnt[r] + CNT_W'(1);
        end else if (w_dec[r] && !w_inc[r] && (r_cnt[r] != '0)) begin
          r_cnt[r] <= r_cnt[r] - CNT_W'(1);
        end
      end
      r_err <= r_err | w_underflow;
    end
  end

  assign bus.rd1       = w_rd1;
  assign bus.rd2       = w_rd2;
  assign bus.busy1     = w_busy1;
  assign bus.busy2     = w_busy2;
  assign bus.stall     = w_busy1 | w_busy2;
  assign bus.iss_ready = w_iss_ready;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_grf_wb_sink.sv
// tb/tb_grf_wb_sink.sv - scoreboard bench for grf_wb_sink
module tb_grf_wb_sink;
  logic clk;
  logic reset;

  grf_wb_sink_if #(.DATA_W(32)) bus ();

  grf_wb_sink #(.DATA_W(32), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic        st;
    logic        ir;
    logic        er;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", n, f, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so each queued expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "rd1",       bus.rd1,                 e.rd1);
      chk(e.name, "rd2",       bus.rd2,                 e.rd2);
      chk(e.name, "busy1",     {31'd0, bus.busy1},      {31'd0, e.b1});
      chk(e.name, "busy2",     {31'd0, bus.busy2},      {31'd0, e.b2});
      chk(e.name, "stall",     {31'd0, bus.stall},      {31'd0, e.st});
      chk(e.name, "iss_ready", {31'd0, bus.iss_ready},  {31'd0, e.ir});
      chk(e.name, "err",       {31'd0, bus.err},        {31'd0, e.er});
    end
  end

  task automatic drive(input logic rst, input logic we_, input logic [4:0] wa_, input logic [31:0] wd_,
                       input logic ie, input logic [4:0] ia, input logic [4:0] a1, input logic [4:0] a2);
    reset        = rst;
    bus.we       = we_;
    bus.wa       = wa_;
    bus.wd       = wd_;
    bus.iss_en   = ie;
    bus.iss_addr = ia;
    bus.ra1      = a1;
    bus.ra2      = a2;
  endtask

  task automatic expect_out(input string n, input logic [31:0] e1, input logic [31:0] e2,
                            input logic b1, input logic b2, input logic st, input logic ir, input logic er);
    exp_t e;
    e.name = n; e.rd1 = e1; e.rd2 = e2; e.b1 = b1; e.b2 = b2; e.st = st; e.ir = ir; e.er = er;
    q.push_back(e);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc; cyc;
    // Reset has priority over a simultaneous write.
    drive(0, 1, 5, 32'h1234, 0, 0, 5, 0);                   cyc;
    drive(1, 0, 0, 0, 0, 0, 5, 0);
    expect_out("reset_rd", 0, 0, 0, 0, 0, 1, 0);            cyc;

    // Write, bypass, $0
    drive(1, 0, 0, 0, 1, 8, 8, 0);
    expect_out("iss8", 0, 0, 0, 0, 0, 1, 0);                cyc;
    drive(1, 1, 8, 32'hDEADBEEF, 0, 0, 8, 0);
    expect_out("bypass8", 32'hDEADBEEF, 0, 0, 0, 0, 1, 0);  cyc;
    drive(1, 0, 0, 0, 0, 0, 8, 0);
    expect_out("reg8", 32'hDEADBEEF, 0, 0, 0, 0, 1, 0);     cyc;
    drive(1, 1, 0, 32'hFFFFFFFF, 0, 0, 8, 0);
    expect_out("wr0_same", 32'hDEADBEEF, 0, 0, 0, 0, 1, 0); cyc;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    expect_out("wr0_after", 0, 0, 0, 0, 0, 1, 0);           cyc;

    // Scoreboard on $31
    drive(1, 0, 0, 0, 1, 31, 31, 31);
    expect_out("iss31", 0, 0, 0, 0, 0, 1, 0);               cyc;
    drive(1, 0, 0, 0, 0, 0, 31, 31);
    expect_out("busy31", 0, 0, 1, 1, 1, 1, 0);              cyc;
    drive(1, 1, 31, 32'h00400008, 0, 0, 31, 31);
    expect_out("retire31", 32'h00400008, 32'h00400008, 0, 0, 0, 1, 0); cyc;
    drive(1, 0, 0, 0, 0, 0, 31, 31);
    expect_out("idle31", 32'h00400008, 32'h00400008, 0, 0, 0, 1, 0);   cyc;

    // Saturation on reg 9
    drive(1, 0, 0, 0, 1, 9, 9, 0);
    expect_out("iss9_a", 0, 0, 0, 0, 0, 1, 0);              cyc;
    drive(1, 0, 0, 0, 1, 9, 9, 0);
    expect_out("iss9_b", 0, 0, 1, 0, 1, 1, 0);              cyc;
    drive(1, 0, 0, 0, 1, 9, 9, 0);
    expect_out("iss9_c", 0, 0, 1, 0, 1, 1, 0);              cyc;
    drive(1, 0, 0, 0, 1, 9, 9, 0);
    expect_out("iss9_full", 0, 0, 1, 0, 1, 0, 0);           cyc;
    drive(1, 1, 9, 32'h99, 1, 9, 9, 0);
    expect_out("iss9_room", 32'h99, 0, 1, 0, 1, 1, 0);      cyc;
    drive(1, 0, 0, 0, 0, 9, 9, 0);
    expect_out("cnt9_held", 32'h99, 0, 1, 0, 1, 0, 0);      cyc;
    drive(1, 1, 9, 32'hA1, 0, 0, 9, 0);
    expect_out("ret9_1", 32'hA1, 0, 1, 0, 1, 1, 0);         cyc;
    drive(1, 1, 9, 32'hA2, 0, 0, 9, 0);
    expect_out("ret9_2", 32'hA2, 0, 1, 0, 1, 1, 0);         cyc;
    drive(1, 1, 9, 32'hA3, 0, 0, 9, 0);
    expect_out("ret9_3", 32'hA3, 0, 0, 0, 0, 1, 0);         cyc;
    drive(1, 0, 0, 0, 0, 0, 9, 0);
    expect_out("idle9", 32'hA3, 0, 0, 0, 0, 1, 0);          cyc;

    // Simultaneous issue/retire at zero, then a true underflow
    drive(1, 1, 13, 32'h1313, 1, 13, 13, 0);
    expect_out("issret13", 32'h1313, 0, 0, 0, 0, 1, 0);     cyc;
    drive(1, 0, 0, 0, 0, 0, 13, 0);
    expect_out("idle13", 32'h1313, 0, 0, 0, 0, 1, 0);       cyc;
    drive(1, 1, 12, 32'hC0C0, 0, 0, 12, 0);
    expect_out("under12", 32'hC0C0, 0, 0, 0, 0, 1, 0);      cyc;
    drive(1, 0, 0, 0, 0, 0, 12, 0);
    expect_out("err_set", 32'hC0C0, 0, 0, 0, 0, 1, 1);      cyc;
    drive(1, 0, 0, 0, 0, 0, 12, 0);
    expect_out("err_held", 32'hC0C0, 0, 0, 0, 0, 1, 1);     cyc;

    // Reset mid-flight
    drive(1, 0, 0, 0, 1, 4, 4, 0);
    expect_out("iss4_a", 0, 0, 0, 0, 0, 1, 1);              cyc;
    drive(1, 1, 4, 32'h55, 1, 4, 4, 0);
    expect_out("iss4_wr", 32'h55, 0, 0, 0, 0, 1, 1);        cyc;
    drive(1, 0, 0, 0, 1, 4, 4, 0);
    expect_out("iss4_b", 32'h55, 0, 1, 0, 1, 1, 1);         cyc;
    drive(1, 0, 0, 0, 0, 4, 4, 4);
    expect_out("pend4", 32'h55, 32'h55, 1, 1, 1, 1, 1);     cyc;
    drive(0, 0, 0, 0, 0, 4, 4, 4);                          cyc;
    drive(1, 0, 0, 0, 0, 4, 4, 4);
    expect_out("post_rst", 0, 0, 0, 0, 0, 1, 0);            cyc;
    drive(1, 1, 4, 32'h7, 0, 0, 4, 0);
    expect_out("ret4_zero", 32'h7, 0, 0, 0, 0, 1, 0);       cyc;
    drive(1, 0, 0, 0, 0, 0, 4, 0);
    expect_out("err_again", 32'h7, 0, 0, 0, 0, 1, 1);       cyc;

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cyc; cyc;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/grf_wb_sink.md
Name: grf_wb_sink

Overview:
- Writeback-side sink of the GRF write interface: a 32x32 general register file.
- Consumes the write address chosen by the register-destination select (rt/rd/$31) and the data chosen by the writeback-data select (ALU result / memory data / PC+4).
- Provides two read ports with write-to-read bypass.
- Keeps a per-register pending-write scoreboard: decode marks a destination at issue, writeback retires it, and stall is raised for reads of registers still in flight.

Parameters:
- DATA_W, 32, register width.
- CNT_W, 2, per-register in-flight counter width; at most 2^CNT_W-1 outstanding writers per register.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge clears all state.
- ra1  in  5  read address 1 (rs).
- ra2  in  5  read address 2 (rt).
- rd1  out  DATA_W  read data 1, combinational.
- rd2  out  DATA_W  read data 2, combinational.
- we  in  1  writeback enable.
- wa  in  5  writeback register address.
- wd  in  DATA_W  writeback data.
- iss_en  in  1  decode issues an instruction writing iss_addr.
- iss_addr  in  5  destination of the issuing instruction.
- iss_ready  out  1  issue accepted this cycle if iss_en.
- busy1  out  1  ra1 has an outstanding writer.
- busy2  out  1  ra2 has an outstanding writer.
- stall  out  1  busy1 | busy2.
- err  out  1  sticky; writeback retired a register with no outstanding writer.

Behaviour:
- **State:** regs[1..31] (DATA_W each); cnt[1..31] (CNT_W each); err flag. $0 has no storage.
- **Reset** (reset==0 at edge): all regs=0, all cnt=0, err=0. Reset takes priority over a simultaneous we/iss_en. The next cycle shows rd1=rd2=0, busy1=busy2=stall=0, iss_ready=1, err=0. Reset mid-flight discards all pending counts.
- **Register write:** at the edge, if we && wa!=0 then regs[wa]<=wd. Writes to $0 are dropped.
- **Read, combinational:**
  - ra==0 -> 0.
  - else if we && wa==ra -> wd (same-cycle bypass).
  - else regs[ra].
- **Counter update** per register r!=0 at the edge:
  - inc = iss_en && iss_ready && iss_addr==r.
  - dec = we && wa==r.
  - inc&&!dec -> cnt+1.
  - dec&&!inc -> cnt-1 if cnt>0; if cnt==0, cnt stays 0 and err<=1.
  - both -> unchanged; a simultaneous issue and retire of the same register never sets err, even at cnt==0.
- **Issue acceptance:** iss_ready = (iss_addr==0) || cnt[iss_addr]!=max || (we && wa==iss_addr). At max the simultaneous retire makes room. iss_en to $0 is accepted and has no effect.
- **Busy:** busyN = (raN!=0) && (cnt[raN] > ((we && wa==raN) ? 1 : 0)).
  - Retiring the last writer this cycle clears busy in the same cycle, consistent with the bypass.
  - An issue in the same cycle does not affect busy; it becomes visible next cycle.
- **stall** is purely combinational from busy1/busy2.
- **err** stays 1 until reset.
- **Arithmetic:** counters are unsigned, never wrap. Overflow is prevented by iss_ready; underflow is clamped and flagged.
- **Latency:**
  - Write is visible via regs one cycle after we, and same cycle via bypass.
  - A scoreboard increment is visible one cycle after issue.

Test Plan:
1. **Reset:** drive reset=0 with we=1, wa=5, wd=0x1234; release; read ra1=5 -> rd1=0, busy1=0, err=0.
2. **Write/bypass/$0:**
   - we=1, wa=8, wd=0xDEADBEEF with ra1=8 -> rd1=0xDEADBEEF same cycle; next cycle with we=0 -> rd1=0xDEADBEEF.
   - we=1, wa=0, wd=0xFFFFFFFF -> ra2=0 reads 0 before and after the edge.
3. **Scoreboard:**
   - iss_en, iss_addr=31 -> next cycle ra1=31 gives busy1=1, stall=1.
   - Then we=1, wa=31, wd=0x00400008 -> same cycle busy1=0, rd1=0x00400008.
   - Next cycle cnt=0, stall=0.
4. **Saturation:**
   - Three issues to reg 9 -> iss_ready=0 for iss_addr=9; a 4th iss_en leaves cnt=3.
   - With we=1, wa=9 the same cycle -> iss_ready=1, cnt stays 3.
5. **Underflow:**
   - we=1, wa=12 with cnt[12]=0 -> data written, err=1 next cycle and held.
   - Simultaneous iss_en/we to reg 13 at cnt=0 -> cnt stays 0, err not set by it.
6. **Reset mid-operation:** with cnt[4]=2 and reg4=0x55, pulse reset=0 for one cycle -> cnt[4]=0, busy=0, reg4=0, err=0.
